iob_vexriscv_bus_bridge: RTL and testbench
==========================================

// Module: iob_vexriscv_bus_bridge
// PURPOSE
//  Parametrised bridge from a VexRiscv cmd/rsp bus (valid/ready cmd, valid-only rsp) to the IOb native bus.
//  Successor to the fixed per-core ibus/dbus glue:
//   - configurable data/address width
//   - splits cache-line refill bursts into IOb beats
//   - tracks up to 2**OUT_W outstanding read beats, regenerating rsp_last
//   - optional boot/peripheral MSB remap
//  One instance is placed per VexRiscv bus (ibus and dbus).
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width; beat bytes BB=DATA_W/8; power of 2, >=32
//  MAXB_W     3  log2 max beats per burst (8 beats)
//  OUT_W      2  log2 outstanding read-beat tracking FIFO depth (4)
//  REMAP_EN   1  1: drive addr MSB from boot/P_BIT/E_BIT rule; 0: pass through
//  P_BIT     30  peripheral-select address bit (used when REMAP_EN=1)
//  E_BIT     29  external-memory-force address bit (used when REMAP_EN=1)
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous reset, active-high
//  cke_i         in   1           clock enable; 0 holds all state
//  boot_i        in   1           boot status for remap
//  cmd_valid_i   in   1           VexRiscv cmd valid
//  cmd_ready_o   out  1           cmd accepted when valid&ready
//  cmd_wr_i      in   1           1 write, 0 read
//  cmd_addr_i    in   ADDR_W      byte address
//  cmd_data_i    in   DATA_W      write data
//  cmd_mask_i    in   DATA_W/8    write byte mask
//  cmd_size_i    in   3           log2 bytes of transfer
//  rsp_valid_o   out  1           read beat valid
//  rsp_data_o    out  DATA_W      read data
//  rsp_last_o    out  1           last beat of a read command
//  rsp_error_o   out  1           always 0
//  iob_avalid_o  out  1           IOb request valid
//  iob_addr_o    out  ADDR_W      IOb address, BB-aligned
//  iob_wdata_o   out  DATA_W      IOb write data
//  iob_wstrb_o   out  DATA_W/8    IOb strobe; 0 = read
//  iob_ready_i   in   1           IOb request accepted when avalid&ready
//  iob_rvalid_i  in   1           IOb read data valid, in order
//  iob_rdata_i   in   DATA_W      IOb read data
//  err_o         out  1           sticky: rvalid received with empty tracking FIFO
// BEHAVIOUR
//  Reset: state IDLE, beat ctr 0, FIFO empty, err_o=0; outputs 0 except echoes of inputs (wdata, rdata).
//  Beats N = (size<=log2 BB) ? 1 : 2**size/BB; size > log2(BB)+MAXB_W is clamped to max beats.
//  Writes: always 1 beat, IDLE only.
//   - avalid=cmd_valid, wstrb=mask, cmd_ready=iob_ready (combinational, 0 added latency)
//   - no response and no FIFO push
//  Reads are gated by FIFO space: space = count<DEPTH, or count==DEPTH with pop in the same cycle.
//  IDLE, N=1 read:
//   - avalid = cmd_valid&space; wstrb=0
//   - cmd_ready = iob_ready&space; on accept push last=1
//  IDLE, N>1 read:
//   - beat 0 same as N=1, addr aligned down to N*BB; on accept push last=0 and go to BURST
//   - cmd_ready stays 0 on beat 0
//  BURST:
//   - avalid = space; addr = base + ctr*BB; ctr increments per accepted beat
//   - each accepted beat pushes last=(ctr==N-1)
//   - cmd_ready=1 only in the cycle the final beat is accepted, then return to IDLE
//   - cmd_valid must stay high and cmd fields stable throughout BURST
//  Response path, combinational:
//   - rsp_valid=iob_rvalid&~empty; rsp_data=iob_rdata; rsp_last=FIFO head; pop on rsp_valid
//   - rvalid with FIFO empty: beat dropped, err_o set until reset
//   - push and pop in the same cycle: count unchanged, allowed at full
//  Remap (REMAP_EN=1): iob_addr_o[ADDR_W-1] = (~boot_i&~a[P_BIT])|a[E_BIT]; lower bits pass through.
//  Reset mid-burst: return to IDLE, clear FIFO/ctr. Late rvalids after reset set err_o; integration must quiesce first.
// TESTING
//  1) Write 0x8000_0010 data 0xDEADBEEF mask 0xF, iob_ready=1 -> same-cycle avalid, wstrb=0xF, cmd_ready=1; no rsp.
//  2) Read size=2 at 0x104, rvalid 2 cycles later rdata 0x1234 -> one rsp_valid, rsp_last=1, data 0x1234.
//  3) Read size=5 (32B) at 0x20C -> 8 beats at 0x200..0x21C; cmd_ready only on 8th accept; 8th rsp has rsp_last=1, rest 0.
//  4) iob_ready held 0 for 3 cycles mid-burst -> addr/ctr hold, no beat skipped or repeated.
//  5) OUT_W=2, rvalid withheld -> 4 read beats issued, avalid low while full; one rvalid -> next beat issued the same cycle.
//  6) rvalid with empty FIFO -> err_o=1 and stays set; rst_i mid-burst -> state IDLE, FIFO count 0 next cycle.

Source files
------------

// File: rtl/iob_vexriscv_bus_bridge.sv
// VexRiscv cmd/rsp to IOb native bus bridge: splits refill bursts into beats,
// tracks outstanding read beats to regenerate rsp_last, optional address MSB remap.
module iob_vexriscv_bus_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAXB_W   = 3,
  parameter int OUT_W    = 2,
  parameter int REMAP_EN = 1,
  parameter int P_BIT    = 30,
  parameter int E_BIT    = 29
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cke_i,
  input  logic                boot_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wr_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_data_i,
  input  logic [DATA_W/8-1:0] cmd_mask_i,
  input  logic [2:0]          cmd_size_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_last_o,
  output logic                rsp_error_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                err_o
);

  localparam int BB    = DATA_W / 8;
  localparam int BB_W  = $clog2(BB);
  localparam int DEPTH = 2 ** OUT_W;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [MAXB_W-1:0]   ctr_q, ctr_d;
  logic [OUT_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUT_W:0]      count_q, count_d;
  logic [DEPTH-1:0]    fifo_q;
  logic                err_q, err_d;

  int unsigned         nlog;
  logic [MAXB_W-1:0]   last_idx;
  logic [ADDR_W-1:0]   base_addr, beat_addr;
  logic                empty, pop, space_ok, accept, push, push_last;

  // Burst length and base: writes are always a single beat.
  always_comb begin
    nlog = 0;
    if (!cmd_wr_i && int'(cmd_size_i) > BB_W) begin
      nlog = int'(cmd_size_i) - BB_W;
      if (nlog > MAXB_W) nlog = MAXB_W;
    end
    last_idx  = MAXB_W'((32'd1 << nlog) - 32'd1);
    base_addr = cmd_addr_i & ~ADDR_W'((BB << nlog) - 1);
    beat_addr = base_addr + (ADDR_W'(ctr_q) << BB_W);
  end

  always_comb begin
    iob_addr_o = beat_addr;
    if (REMAP_EN != 0) begin
      iob_addr_o[ADDR_W-1] = (~boot_i & ~beat_addr[P_BIT]) | beat_addr[E_BIT];
    end
  end

  assign empty    = (count_q == '0);
  assign pop      = cke_i & iob_rvalid_i & ~empty;
  // A pop in the same cycle frees the slot the new push needs.
  assign space_ok = cke_i & ((count_q != (OUT_W+1)'(DEPTH)) | pop);

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default on any branch would infer a latch.
  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    iob_avalid_o = 1'b0;
    iob_wstrb_o  = '0;
    cmd_ready_o  = 1'b0;
    accept       = 1'b0;
    push         = 1'b0;
    push_last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_wr_i) begin
          iob_avalid_o = cmd_valid_i & cke_i;
          iob_wstrb_o  = cmd_mask_i;
          cmd_ready_o  = iob_ready_i & cke_i;
        end else begin
          iob_avalid_o = cmd_valid_i & space_ok;
          accept       = iob_avalid_o & iob_ready_i;
          push         = accept;
          if (last_idx == '0) begin
            cmd_ready_o = iob_ready_i & space_ok;
            push_last   = 1'b1;
          end else if (accept) begin
            ctr_d   = MAXB_W'(1);
            state_d = BURST;
          end
        end
      end
      BURST: begin
        iob_avalid_o = space_ok;
        accept       = iob_avalid_o & iob_ready_i;
        push         = accept;
        push_last    = (ctr_q == last_idx);
        if (accept) begin
          if (ctr_q == last_idx) begin
            cmd_ready_o = 1'b1;
            ctr_d       = '0;
            state_d     = IDLE;
          end else begin
            ctr_d = ctr_q + MAXB_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q + OUT_W'(push);
    rptr_d  = rptr_q + OUT_W'(pop);
    count_d = count_q + (OUT_W+1)'(push) - (OUT_W+1)'(pop);
    err_d   = err_q | (cke_i & iob_rvalid_i & empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (cke_i) begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the flag storage is deliberately not reset; the pointers and count
  // define which entries are valid, and the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (cke_i && push) fifo_q[wptr_q] <= push_last;
  end

  assign rsp_valid_o = pop;
  assign rsp_data_o  = iob_rdata_i;
  assign rsp_last_o  = fifo_q[rptr_q] & ~empty;
  assign rsp_error_o = 1'b0;
  assign iob_wdata_o = cmd_data_i;
  assign err_o       = err_q;

endmodule

// File: tb/tb_iob_vexriscv_bus_bridge.sv
// Directed bench for iob_vexriscv_bus_bridge: a table of single-cycle request
// vectors plus hand-written burst, back-pressure, FIFO-full and reset sequences.
module tb_iob_vexriscv_bus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        boot = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [3:0]  cmd_mask = '0;
  logic [2:0]  cmd_size = '0;
  logic        rsp_valid, rsp_last, rsp_error;
  logic [31:0] rsp_data;
  logic        iob_avalid, iob_ready = 1'b0, iob_rvalid = 1'b0;
  logic [31:0] iob_addr, iob_wdata, iob_rdata = '0;
  logic [3:0]  iob_wstrb;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  iob_vexriscv_bus_bridge dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .boot_i(boot),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_mask_i(cmd_mask),
    .cmd_size_i(cmd_size),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .rsp_error_o(rsp_error),
    .iob_avalid_o(iob_avalid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata), .err_o(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive_cmd(input logic v, input logic wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [3:0] m, input logic [31:0] d);
    cmd_valid = v; cmd_wr = wr; cmd_addr = a; cmd_size = sz; cmd_mask = m; cmd_data = d;
  endtask

  typedef struct {
    logic        boot;
    logic        valid;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        ready;
    logic        e_avalid;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic        e_cmd_ready;
  } vec_t;

  vec_t vecs[10];

  logic        rdy_pat  [7];
  logic [31:0] addr_pat [7];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 32'h8000_0010, 3'd2, 4'hF, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h8000_0010, 4'hF, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0013, 3'd2, 4'h3, 32'h0000_1111, 1'b0, 1'b1, 32'h0000_0010, 4'h3, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h2000_0040, 3'd2, 4'hC, 32'hA5A5_5A5A, 1'b1, 1'b1, 32'hA000_0040, 4'hC, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h4000_0008, 3'd2, 4'h1, 32'h0BAD_F00D, 1'b1, 1'b1, 32'h4000_0008, 4'h1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 3'd2, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_0104, 4'h0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_020C, 3'd5, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_0200, 4'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_1234, 3'd7, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_1220, 4'h0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_0107, 3'd0, 4'h0, 32'h0,          1'b0, 1'b1, 32'h0000_0104, 4'h0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_000C, 3'd3, 4'h0, 32'h0,          1'b0, 1'b1, 32'h8000_0008, 4'h0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 32'h0000_020C, 3'd5, 4'h0, 32'h0,          1'b1, 1'b0, 32'h0000_0200, 4'h0, 1'b0};

    rdy_pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    addr_pat = '{32'h300, 32'h304, 32'h308, 32'h308, 32'h308, 32'h308, 32'h30C};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_avalid", iob_avalid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_wstrb", iob_wstrb, 0);
    check("rst_err", err, 0);
    check("rst_rsp_error", rsp_error, 0);

    // Single-cycle request vectors: writes accepted, reads held off by iob_ready=0
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      boot = vecs[i].boot; iob_ready = vecs[i].ready;
      drive_cmd(vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].mask, vecs[i].data);
      #1;
      check($sformatf("vec%0d_avalid", i), iob_avalid, vecs[i].e_avalid);
      check($sformatf("vec%0d_addr", i), iob_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_wstrb", i), iob_wstrb, vecs[i].e_wstrb);
      check($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].e_cmd_ready);
      check($sformatf("vec%0d_wdata", i), iob_wdata, vecs[i].data);
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, 0);
    end
    @(negedge clk); drive_cmd(0, 0, 0, 0, 0, 0); iob_ready = 1'b0; boot = 1'b1;

    // Single-beat read, response two cycles later
    @(negedge clk);
    drive_cmd(1, 0, 32'h104, 3'd2, 0, 0); iob_ready = 1'b1; #1;
    check("rd1_avalid", iob_avalid, 1);
    check("rd1_addr", iob_addr, 32'h104);
    check("rd1_cmd_ready", cmd_ready, 1);
    @(negedge clk); drive_cmd(0, 0, 0, 0, 0, 0); iob_ready = 1'b0;
    @(negedge clk); iob_rvalid = 1'b1; iob_rdata = 32'h1234; #1;
    check("rd1_rsp_valid", rsp_valid, 1);
    check("rd1_rsp_last", rsp_last, 1);
    check("rd1_rsp_data", rsp_data, 32'h1234);
    @(negedge clk); iob_rvalid = 1'b0; #1;
    check("rd1_err", err, 0);

    // 8-beat refill, responses streamed one cycle behind each beat
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      drive_cmd(k < 8, 0, 32'h20C, 3'd5, 0, 0); iob_ready = 1'b1;
      iob_rvalid = (k >= 1); iob_rdata = 32'(k - 1);
      #1;
      if (k < 8) begin
        check($sformatf("b8_avalid%0d", k), iob_avalid, 1);
        check($sformatf("b8_addr%0d", k), iob_addr, 32'h200 + 32'(4 * k));
        check($sformatf("b8_cmd_ready%0d", k), cmd_ready, (k == 7));
      end
      if (k >= 1) begin
        check($sformatf("b8_rsp_valid%0d", k), rsp_valid, 1);
        check($sformatf("b8_rsp_last%0d", k), rsp_last, (k == 8));
        check($sformatf("b8_rsp_data%0d", k), rsp_data, 32'(k - 1));
      end
    end
    @(negedge clk); drive_cmd(0, 0, 0, 0, 0, 0); iob_rvalid = 1'b0; iob_ready = 1'b0;

    // 4-beat read with iob_ready stalled for three cycles mid-burst
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      drive_cmd(1, 0, 32'h300, 3'd4, 0, 0); iob_ready = rdy_pat[k]; #1;
      check($sformatf("stall_avalid%0d", k), iob_avalid, 1);
      check($sformatf("stall_addr%0d", k), iob_addr, addr_pat[k]);
      check($sformatf("stall_cmd_ready%0d", k), cmd_ready, (k == 6));
    end
    @(negedge clk); drive_cmd(0, 0, 0, 0, 0, 0); iob_ready = 1'b0;

    // Tracking FIFO now full: next read waits until a response frees a slot
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_cmd(1, 0, 32'h400, 3'd4, 0, 0); iob_ready = 1'b1; #1;
      check($sformatf("full_avalid%0d", k), iob_avalid, 0);
      check($sformatf("full_cmd_ready%0d", k), cmd_ready, 0);
    end
    @(negedge clk); iob_rvalid = 1'b1; iob_rdata = 32'h55; #1;
    check("full_pop_rsp_valid", rsp_valid, 1);
    check("full_pop_rsp_last", rsp_last, 0);
    check("full_pop_avalid", iob_avalid, 1);
    check("full_pop_addr", iob_addr, 32'h400);
    @(negedge clk); iob_rvalid = 1'b0; #1;
    check("full_again_avalid", iob_avalid, 0);

    // Reset mid-burst with a full FIFO, then a stray response
    @(negedge clk); rst = 1'b1; drive_cmd(0, 0, 0, 0, 0, 0); iob_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check("mid_rst_err", err, 0);
    check("mid_rst_avalid", iob_avalid, 0);
    @(negedge clk); iob_rvalid = 1'b1; iob_rdata = 32'h77; #1;
    check("stray_rsp_valid", rsp_valid, 0);
    @(negedge clk); iob_rvalid = 1'b0; #1;
    check("stray_err_set", err, 1);
    repeat (3) @(negedge clk);
    #1;
    check("stray_err_sticky", err, 1);

    // After reset the burst restarts at beat 0 and all four beats fit
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive_cmd(1, 0, 32'h500, 3'd4, 0, 0); iob_ready = 1'b1; #1;
      check($sformatf("post_rst_avalid%0d", k), iob_avalid, 1);
      check($sformatf("post_rst_addr%0d", k), iob_addr, 32'h500 + 32'(4 * k));
      check($sformatf("post_rst_cmd_ready%0d", k), cmd_ready, (k == 3));
    end
    @(negedge clk); drive_cmd(0, 0, 0, 0, 0, 0); iob_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); iob_rvalid = 1'b1; iob_rdata = 32'(k); #1;
      check($sformatf("drain_rsp_valid%0d", k), rsp_valid, 1);
      check($sformatf("drain_rsp_last%0d", k), rsp_last, (k == 3));
    end
    @(negedge clk); iob_rvalid = 1'b0; #1;
    check("drain_empty_rsp_valid", rsp_valid, 0);
    check("final_err", err, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
